bitwise_logic_engine: RTL and testbench



---
 rtl/bitwise_logic_engine.sv | 83 ++++++++
 tb/tb_bitwise_logic_engine.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_engine.sv
// bitwise_logic_engine: multi-cycle chunked bitwise op unit with popcount and zero flag
module bitwise_logic_engine #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] ones,
  output logic             zero
);
  localparam int N = WIDTH / CHUNK;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  if (CHUNK < 1 || WIDTH < CHUNK || WIDTH % CHUNK != 0) begin : g_bad_params
    $error("bitwise_logic_engine: WIDTH must be a positive multiple of CHUNK");
  end
  logic [1:0]       state;
  logic [WIDTH-1:0] ra, rb;
  logic [2:0]       rop;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] ch;
  function automatic logic [CHUNK-1:0] f(input logic [2:0] o, input logic [CHUNK-1:0] x, input logic [CHUNK-1:0] y);
    case (o)
      3'd0:    f = x & y;
      3'd1:    f = x | y;
      3'd2:    f = x ^ y;
      3'd3:    f = ~(x | y);
      3'd4:    f = x & ~y;
      3'd5:    f = ~(x & y);
      3'd6:    f = ~(x ^ y);
      default: f = x;
    endcase
  endfunction
  function automatic logic [CNT_W-1:0] pop(input logic [CHUNK-1:0] v);
    pop = '0;
    for (int i = 0; i < CHUNK; i++) pop = pop + CNT_W'(v[i]);
  endfunction
  assign ch        = f(rop, ra[idx*CHUNK +: CHUNK], rb[idx*CHUNK +: CHUNK]);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign zero      = ones == '0;
  // Operands are latched on accept so later input changes cannot disturb the running op
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      rop    <= '0;
      result <= '0;
      ones   <= '0;
      idx    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ra     <= a;
          rb     <= b;
          rop    <= op;
          result <= '0;
          ones   <= '0;
          idx    <= '0;
          state  <= BUSY;
        end
        BUSY: begin
          result[idx*CHUNK +: CHUNK] <= ch;
          ones <= ones + pop(ch);
          if (idx == IW'(N - 1)) state <= DONE;
          else idx <= idx + 1'b1;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bitwise_logic_engine.sv
// tb_bitwise_logic_engine: scoreboard bench for default config plus two parameter corners
module tb_bitwise_logic_engine;
  logic clock = 0, reset_n = 0;
  always #5 clock = ~clock;
  logic        in_valid = 0, in_ready, out_valid, out_ready = 1, zero;
  logic [2:0]  op = 0;
  logic [31:0] a = 0, b = 0, result;
  logic [5:0]  ones;
  logic        c1_valid = 0, c1_in_ready, c1_out_valid, c1_zero;
  logic [2:0]  c1_op = 0;
  logic [31:0] c1_a = 0, c1_b = 0, c1_result;
  logic [5:0]  c1_ones;
  logic        c2_valid = 0, c2_in_ready, c2_out_valid, c2_zero;
  logic [2:0]  c2_op = 0;
  logic [15:0] c2_a = 0, c2_b = 0, c2_result;
  logic [4:0]  c2_ones;
  bitwise_logic_engine dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .ones(ones), .zero(zero));
  bitwise_logic_engine #(.WIDTH(32), .CHUNK(32)) dut_c1 (
    .clock(clock), .reset_n(reset_n), .in_valid(c1_valid), .in_ready(c1_in_ready), .op(c1_op),
    .a(c1_a), .b(c1_b), .out_valid(c1_out_valid), .out_ready(1'b1), .result(c1_result),
    .ones(c1_ones), .zero(c1_zero));
  bitwise_logic_engine #(.WIDTH(16), .CHUNK(1)) dut_c2 (
    .clock(clock), .reset_n(reset_n), .in_valid(c2_valid), .in_ready(c2_in_ready), .op(c2_op),
    .a(c2_a), .b(c2_b), .out_valid(c2_out_valid), .out_ready(1'b1), .result(c2_result),
    .ones(c2_ones), .zero(c2_zero));
  typedef struct {logic [31:0] r; int o;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Monitor: every accepted output is compared against the oldest expectation
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.r);
        chk("ones", ones, e.o);
        chk("zero", zero, e.r == 0);
      end
    end
  end
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input int eo, input int hold);
    int lat;
    @(posedge clock); #1;
    op = o; a = x; b = y; in_valid = 1; out_ready = hold == 0;
    sb.push_back('{er, eo});
    @(posedge clock); #1;
    in_valid = 0;
    chk("in_ready_busy", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clock); #1; lat++; end
    chk("latency", lat, 4);
    for (int i = 0; i < hold; i++) begin
      a = ~a; b = b ^ 32'h1234; op = op + 3'd3; in_valid = ~in_valid;
      @(posedge clock); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_result", result, er);
      chk("hold_ones", ones, eo);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clock); #1;
    chk("ready_after_hs", in_ready, 1);
    chk("valid_after_hs", out_valid, 0);
  endtask
  initial begin
    int lat;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_zero", zero, 1);
    chk("rst_result", result, 0);
    chk("rst_ones", ones, 0);
    #10 reset_n = 1;
    run_op(3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 8, 0);
    run_op(3'b010, 32'h12345678, 32'h12345678, 32'h00000000, 0, 0);
    run_op(3'b011, 32'h0, 32'h0, 32'hFFFFFFFF, 32, 0);
    run_op(3'b000, 32'h0000FFFF, 32'h00FF00FF, 32'h000000FF, 8, 0);
    run_op(3'b001, 32'h0000FFFF, 32'h00FF00FF, 32'h00FFFFFF, 24, 0);
    run_op(3'b010, 32'h0000FFFF, 32'h00FF00FF, 32'h00FFFF00, 16, 0);
    run_op(3'b011, 32'h0000FFFF, 32'h00FF00FF, 32'hFF000000, 8, 0);
    run_op(3'b100, 32'h0000FFFF, 32'h00FF00FF, 32'h0000FF00, 8, 0);
    run_op(3'b101, 32'h0000FFFF, 32'h00FF00FF, 32'hFFFFFF00, 24, 0);
    run_op(3'b110, 32'h0000FFFF, 32'h00FF00FF, 32'hFF0000FF, 16, 0);
    run_op(3'b111, 32'h0000FFFF, 32'h00FF00FF, 32'h0000FFFF, 16, 0);
    run_op(3'b001, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 32, 3);
    repeat (3) begin @(posedge clock); #1; chk("no_second_op", out_valid, 0); end
    @(posedge clock); #1;
    op = 3'b000; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; in_valid = 1;
    @(posedge clock); #1;
    in_valid = 0;
    @(posedge clock); #1;
    chk("partial_ones", ones, 8);
    reset_n = 0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_zero", zero, 1);
    chk("abort_result", result, 0);
    chk("abort_ones", ones, 0);
    @(negedge clock);
    reset_n = 1;
    run_op(3'b101, 32'h0F0F0F0F, 32'hFFFF0000, 32'hF0F0FFFF, 24, 0);
    @(posedge clock); #1;
    c1_op = 3'b001; c1_a = 32'h0000FFFF; c1_b = 32'h00FF00FF; c1_valid = 1;
    @(posedge clock); #1;
    c1_valid = 0;
    lat = 0;
    while (!c1_out_valid && lat < 10) begin @(posedge clock); #1; lat++; end
    chk("c1_latency", lat, 1);
    chk("c1_result", c1_result, 32'h00FFFFFF);
    chk("c1_ones", c1_ones, 24);
    chk("c1_zero", c1_zero, 0);
    @(posedge clock); #1;
    c2_op = 3'b100; c2_a = 16'hFFFF; c2_b = 16'h8001; c2_valid = 1;
    @(posedge clock); #1;
    c2_valid = 0;
    lat = 0;
    while (!c2_out_valid && lat < 40) begin @(posedge clock); #1; lat++; end
    chk("c2_latency", lat, 16);
    chk("c2_result", c2_result, 16'h7FFE);
    chk("c2_ones", c2_ones, 14);
    chk("c2_zero", c2_zero, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
